// File: rtl/axi_stream_pkg.sv
// Shared types and default widths for the AXI-stream header-strip slice.
package axi_stream_pkg;

  localparam int DEF_DATA_WD      = 32;
  localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    STREAM,
    TAIL
  } state_e;

endpackage

// File: rtl/axi_stream_out_reg.sv
// One-entry registered valid/ready slice; payload holds while valid && !ready.
module axi_stream_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_data,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  assign load_ready = !valid || ready;

  // NOTE: registers get an async reset and are written with <= only, so every
  // flop sees the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load_ready) begin
      valid <= load_valid;
      if (load_valid) data <= load_data;
    end
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips the first N bytes of each packet onto a header port and realigns the rest.
module axi_stream_strip_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    last_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    valid_hdr,
  input  logic                    ready_hdr,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] keep_hdr
);

  localparam int PAY_W = 1 + DATA_BYTE_WD + DATA_WD;
  localparam int HDR_W = DATA_BYTE_WD + DATA_WD;

  state_e                  state;
  logic [BYTE_CNT_WD:0]    n_q;
  logic [BYTE_CNT_WD:0]    rem_n;
  logic [DATA_WD-1:0]      data_m, res_data, next_res_data, pay_data;
  logic [DATA_BYTE_WD-1:0] res_keep, next_res_keep, pay_keep;
  logic                    more_than_n, accept, pay_last;
  logic                    pay_load_valid, pay_load_ready;
  logic                    hdr_load_valid, hdr_load_ready;
  logic [PAY_W-1:0]        pay_q;
  logic [HDR_W-1:0]        hdr_q;

  function automatic logic [DATA_WD-1:0] keep_to_mask(input logic [DATA_BYTE_WD-1:0] k);
    for (int i = 0; i < DATA_BYTE_WD; i++) keep_to_mask[8*i +: 8] = {8{k[i]}};
  endfunction

  // Byte 0 is the MSB byte; absent bytes are zeroed before any shifting.
  assign rem_n         = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD) - n_q;
  assign data_m        = data_in & keep_to_mask(keep_in);
  assign next_res_data = data_m << {n_q, 3'b000};
  assign next_res_keep = keep_in << n_q;
  assign more_than_n   = |next_res_keep;
  assign ready_strip   = (state == IDLE);

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ready_in       = 1'b0;
    pay_load_valid = 1'b0;
    pay_data       = next_res_data;
    pay_keep       = next_res_keep;
    pay_last       = 1'b1;
    case (state)
      FIRST:   ready_in = hdr_load_ready && pay_load_ready;
      STREAM:  ready_in = pay_load_ready;
      default: ready_in = 1'b0;
    endcase
    accept = valid_in && ready_in;
    case (state)
      FIRST: pay_load_valid = accept && last_in && more_than_n;
      STREAM: begin
        pay_load_valid = accept;
        pay_data       = res_data | (data_m >> {rem_n, 3'b000});
        pay_keep       = res_keep | (keep_in >> rem_n);
        pay_last       = last_in && !more_than_n;
      end
      TAIL: begin
        pay_load_valid = 1'b1;
        pay_data       = res_data;
        pay_keep       = res_keep;
      end
      default: pay_load_valid = 1'b0;
    endcase
  end

  assign hdr_load_valid = (state == FIRST) && accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_q      <= '0;
      res_data <= '0;
      res_keep <= '0;
    end else begin
      case (state)
        IDLE: if (valid_strip) begin
          n_q   <= strip_cnt;
          state <= FIRST;
        end
        FIRST: if (accept) begin
          res_data <= next_res_data;
          res_keep <= next_res_keep;
          state    <= last_in ? IDLE : STREAM;
        end
        STREAM: if (accept) begin
          res_data <= next_res_data;
          res_keep <= next_res_keep;
          if (last_in) state <= more_than_n ? TAIL : IDLE;
        end
        TAIL: if (pay_load_ready) begin
          res_data <= '0;
          res_keep <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axi_stream_out_reg #(.W(PAY_W)) u_pay_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (pay_load_valid),
    .load_ready (pay_load_ready),
    .load_data  ({pay_last, pay_keep, pay_data}),
    .valid      (valid_out),
    .ready      (ready_out),
    .data       (pay_q)
  );

  axi_stream_out_reg #(.W(HDR_W)) u_hdr_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (hdr_load_valid),
    .load_ready (hdr_load_ready),
    .load_data  ({keep_in >> rem_n, data_m >> {rem_n, 3'b000}}),
    .valid      (valid_hdr),
    .ready      (ready_hdr),
    .data       (hdr_q)
  );

  assign {last_out, keep_out, data_out} = pay_q;
  assign {keep_hdr, header_out}         = hdr_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header: hand-computed header/payload beats.
module tb_axi_stream_strip_header;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, last_in = 1'b0, ready_in;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        valid_strip = 1'b0, ready_strip;
  logic [2:0]  strip_cnt = '0;
  logic        valid_out, last_out, ready_out = 1'b1;
  logic [31:0] data_out, header_out;
  logic [3:0]  keep_out, keep_hdr;
  logic        valid_hdr, ready_hdr = 1'b1;
  logic        rand_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_pay[$];
  logic [63:0] exp_hdr[$];
  logic        pay_stall = 1'b0, hdr_stall = 1'b0;
  logic [63:0] pay_held, hdr_held;

  axi_stream_strip_header dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .last_in(last_in),
    .data_in(data_in), .keep_in(keep_in),
    .valid_strip(valid_strip), .strip_cnt(strip_cnt), .ready_strip(ready_strip),
    .valid_out(valid_out), .last_out(last_out), .ready_out(ready_out),
    .data_out(data_out), .keep_out(keep_out),
    .valid_hdr(valid_hdr), .ready_hdr(ready_hdr),
    .header_out(header_out), .keep_hdr(keep_hdr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pay_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {27'd0, l, k, d};
  endfunction

  function automatic logic [63:0] hdr_word(input logic [31:0] d, input logic [3:0] k);
    return {28'd0, k, d};
  endfunction

  always @(negedge clk) begin
    if (rand_en) begin
      ready_out = 1'($urandom_range(0, 1));
      ready_hdr = 1'($urandom_range(0, 1));
    end else begin
      ready_out = 1'b1;
      ready_hdr = 1'b1;
    end
  end

  // Sampled mid-cycle: a beat seen valid && ready here transfers on the next rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pay_stall = 1'b0;
      hdr_stall = 1'b0;
    end else begin
      if (pay_stall) check("pay_hold", pay_word(data_out, keep_out, last_out), pay_held);
      if (hdr_stall) check("hdr_hold", hdr_word(header_out, keep_hdr), hdr_held);
      if (valid_out && ready_out) begin
        if (exp_pay.size() == 0) check("pay_extra", 64'(valid_out), 64'd0);
        else check("pay_beat", pay_word(data_out, keep_out, last_out), exp_pay.pop_front());
      end
      if (valid_hdr && ready_hdr) begin
        if (exp_hdr.size() == 0) check("hdr_extra", 64'(valid_hdr), 64'd0);
        else check("hdr_beat", hdr_word(header_out, keep_hdr), exp_hdr.pop_front());
      end
      pay_stall = valid_out && !ready_out;
      pay_held  = pay_word(data_out, keep_out, last_out);
      hdr_stall = valid_hdr && !ready_hdr;
      hdr_held  = hdr_word(header_out, keep_hdr);
    end
  end

  task automatic start_pkt(input logic [2:0] n);
    logic hs = 1'b0;
    int   t = 0;
    valid_strip = 1'b1;
    strip_cnt   = n;
    while (!hs && t < 200) begin
      #1 hs = ready_strip;
      @(posedge clk);
      if (!hs) @(negedge clk);
      t++;
    end
    if (!hs) check("strip_timeout", 64'(hs), 64'd1);
    @(negedge clk);
    valid_strip = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic hs = 1'b0;
    int   t = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    while (!hs && t < 500) begin
      #1 hs = ready_in;
      @(posedge clk);
      if (!hs) @(negedge clk);
      t++;
    end
    if (!hs) check("beat_timeout", 64'(hs), 64'd1);
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_pay.size() + exp_hdr.size()) != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(exp_pay.size() + exp_hdr.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_req027();
    exp_hdr.push_back(hdr_word(32'h0000AABB, 4'b0011));
    exp_pay.push_back(pay_word(32'hCCDD1122, 4'b1111, 1'b0));
    exp_pay.push_back(pay_word(32'h33445566, 4'b1111, 1'b1));
    start_pkt(3'd2);
    drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    drive_beat(32'h11223344, 4'b1111, 1'b0);
    drive_beat(32'h55667788, 4'b1100, 1'b1);
  endtask

  initial begin
    #3;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_valid_hdr", 64'(valid_hdr), 64'd0);
    check("rst_pay_word", pay_word(data_out, keep_out, last_out), 64'd0);
    check("rst_hdr_word", hdr_word(header_out, keep_hdr), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd0);
    check("rst_ready_strip", 64'(ready_strip), 64'd1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_req027();
    wait_drain("drain_n2");

    // N=1, last beat with more bytes than N forces a TAIL beat
    exp_hdr.push_back(hdr_word(32'h000000AA, 4'b0001));
    exp_pay.push_back(pay_word(32'hBBCCDD11, 4'b1111, 1'b0));
    exp_pay.push_back(pay_word(32'h22330000, 4'b1100, 1'b1));
    start_pkt(3'd1);
    drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    drive_beat(32'h11223300, 4'b1110, 1'b1);
    wait_drain("drain_tail");

    // N=4: zero-shift pass-through
    exp_hdr.push_back(hdr_word(32'h01020304, 4'b1111));
    exp_pay.push_back(pay_word(32'hA0B0C0D0, 4'b1111, 1'b0));
    exp_pay.push_back(pay_word(32'h99887766, 4'b1111, 1'b1));
    start_pkt(3'd4);
    drive_beat(32'h01020304, 4'b1111, 1'b0);
    drive_beat(32'hA0B0C0D0, 4'b1111, 1'b0);
    drive_beat(32'h99887766, 4'b1111, 1'b1);
    wait_drain("drain_n4");

    // N=3, single short beat: header only
    exp_hdr.push_back(hdr_word(32'h00AABBCC, 4'b0111));
    start_pkt(3'd3);
    drive_beat(32'hAABBCC00, 4'b1110, 1'b1);
    wait_drain("drain_hdr_only");
    check("idle_after_hdr_only", 64'(ready_strip), 64'd1);

    // N=2, last beat k=1 gives a partial keep with zero-filled data
    exp_hdr.push_back(hdr_word(32'h00000102, 4'b0011));
    exp_pay.push_back(pay_word(32'h03040A00, 4'b1110, 1'b1));
    start_pkt(3'd2);
    drive_beat(32'h01020304, 4'b1111, 1'b0);
    drive_beat(32'h0A0B0C0D, 4'b1000, 1'b1);
    wait_drain("drain_partial");

    // N=1, single beat with bytes beyond the header
    exp_hdr.push_back(hdr_word(32'h000000AA, 4'b0001));
    exp_pay.push_back(pay_word(32'hBBCC0000, 4'b1100, 1'b1));
    start_pkt(3'd1);
    drive_beat(32'hAABBCCDD, 4'b1110, 1'b1);
    wait_drain("drain_first_last");

    rand_en = 1'b1;
    run_req027();
    run_req027();
    wait_drain("drain_random");
    rand_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in STREAM, then a fresh packet
    exp_hdr.push_back(hdr_word(32'h0000AABB, 4'b0011));
    exp_pay.push_back(pay_word(32'hCCDD1122, 4'b1111, 1'b0));
    start_pkt(3'd2);
    drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    drive_beat(32'h11223344, 4'b1111, 1'b0);
    wait_drain("drain_pre_reset");
    rst_n = 1'b0;
    #3;
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_ready_strip", 64'(ready_strip), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hDEADBEEF;
    keep_in  = 4'b1111;
    last_in  = 1'b1;
    #1 check("postrst_ready_in", 64'(ready_in), 64'd0);
    repeat (4) @(negedge clk);
    check("postrst_no_beat", 64'(valid_out), 64'd0);
    valid_in = 1'b0;
    last_in  = 1'b0;
    exp_hdr.push_back(hdr_word(32'h00000102, 4'b0011));
    exp_pay.push_back(pay_word(32'h03040506, 4'b1111, 1'b1));
    start_pkt(3'd2);
    drive_beat(32'h01020304, 4'b1111, 1'b0);
    drive_beat(32'h05060708, 4'b1100, 1'b1);
    wait_drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
